encoder: RTL and testbench

Serial optical-link transmitter for the LightIO data path. It accepts one FRAME_SIZE-bit parallel frame and drives it onto a single LED output as a start symbol followed by Manchester-coded data bits, MSB first. When the last symbol has been emitted it raises a one-cycle interrupt (irq) so the host can supply the next frame.

---
 rtl/encoder_pkg.sv | 21 ++
 rtl/encoder_bit_timer.sv | 42 ++++
 rtl/encoder.sv | 100 ++++++++++
 tb/tb_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the LightIO optical-link transmitter:
// default frame width, FSM encoding and Manchester polarity.
package encoder_pkg;

    localparam int LINK_FRAME_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // LED level during the first half of a '1' bit (IEEE 802.3: low then high).
    localparam logic MANCH_ONE_FIRST = 1'b0;

    function automatic logic first_half(input logic b);
        return b ? MANCH_ONE_FIRST : ~MANCH_ONE_FIRST;
    endfunction

endpackage

// File: rtl/encoder_bit_timer.sv
// Half-bit timer: counts HALF_BIT_CYCLES per half symbol and strobes at the
// end of each half (half_tick) and of each full bit (bit_tick).
module bit_timer
    import encoder_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic half_tick,
    output logic bit_tick
);

    localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          phase;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (run) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign half_tick = run && (cnt == LAST);
    assign bit_tick  = half_tick && phase;

endmodule

// File: rtl/encoder.sv
// Serial optical-link transmitter: start symbol (one bit period high) followed
// by FRAME_SIZE Manchester-coded bits MSB first, then a one-cycle irq.
module encoder
    import encoder_pkg::*;
#(
    parameter int FRAME_SIZE      = LINK_FRAME_SIZE,
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FRAME_SIZE-1:0] data,
    input  logic                  enable,
    output logic                  led,
    output logic                  irq
);

    localparam int BW = $clog2(FRAME_SIZE + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_SIZE - 1);

    state_t                state, state_nx;
    logic [FRAME_SIZE-1:0] shreg, shreg_nx;
    logic [BW-1:0]         bit_idx, bit_idx_nx;
    logic                  led_nx, irq_nx;
    logic                  start, run, half_tick, bit_tick;

    assign start = (state == IDLE) && enable;
    assign run   = (state == START) || (state == DATA);

    bit_timer #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (start),
        .run       (run),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            led     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_idx <= bit_idx_nx;
            led     <= led_nx;
            irq     <= irq_nx;
        end
    end

    // led is registered, so each transition loads the level for the next cycle.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        led_nx     = led;
        irq_nx     = 1'b0;
        case (state)
            IDLE: begin
                led_nx = 1'b0;
                if (enable) begin
                    state_nx   = START;
                    shreg_nx   = data;
                    bit_idx_nx = '0;
                    led_nx     = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nx = DATA;
                    led_nx   = first_half(shreg[FRAME_SIZE-1]);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_nx = shreg << 1;
                    if (bit_idx == LAST_BIT) begin
                        state_nx = DONE;
                        led_nx   = 1'b0;
                        irq_nx   = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                        led_nx     = first_half(shreg_nx[FRAME_SIZE-1]);
                    end
                end else if (half_tick) begin
                    led_nx = ~led;
                end
            end
            DONE: begin
                state_nx = IDLE;
                led_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_encoder.sv
// Scoreboarded bench for encoder at HALF_BIT_CYCLES = 4, 1 and 7.
module tb_encoder;

    localparam int F = 16;
    localparam int N = 8192;

    typedef struct {
        int          inst;
        logic [15:0] d;
        int          start;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable [3];
    logic [15:0] data   [3];
    logic        led    [3];
    logic        irq    [3];

    exp_t q[$];
    int   cyc = 0;
    int   next_free  [3] = '{0, 0, 0};
    int   busy_until [3] = '{-1, -1, -1};
    logic hist [3][N];
    int   vec  = 0;
    int   miss = 0;

    encoder #(.FRAME_SIZE(F), .HALF_BIT_CYCLES(4)) dut0 (
        .clock(clock), .reset(reset), .data(data[0]), .enable(enable[0]), .led(led[0]), .irq(irq[0]));
    encoder #(.FRAME_SIZE(F), .HALF_BIT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .data(data[1]), .enable(enable[1]), .led(led[1]), .irq(irq[1]));
    encoder #(.FRAME_SIZE(F), .HALF_BIT_CYCLES(7)) dut2 (
        .clock(clock), .reset(reset), .data(data[2]), .enable(enable[2]), .led(led[2]), .irq(irq[2]));

    always #5 clock = ~clock;

    function automatic int hv(input int j);
        return (j == 0) ? 4 : ((j == 1) ? 1 : 7);
    endfunction

    // Line level 'off' cycles after the start edge: one high bit period, then
    // each data bit as (~b, b) halves of h cycles, then low.
    function automatic logic exp_led(input logic [15:0] d, input int h, input int off);
        int b;
        if (off < 2*h) return 1'b1;
        b = (off - 2*h) / (2*h);
        if (b >= F) return 1'b0;
        return (((off - 2*h) % (2*h)) < h) ? ~d[F-1-b] : d[F-1-b];
    endfunction

    // Reference model: a frame starts on any edge with enable high once the
    // previous frame plus its DONE and IDLE cycles are over.
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            q.delete();
            for (int j = 0; j < 3; j++) begin
                next_free[j]  = 0;
                busy_until[j] = -1;
            end
        end else begin
            cyc++;
            for (int j = 0; j < 3; j++) begin
                if (enable[j] && cyc >= next_free[j]) begin
                    q.push_back('{inst: j, d: data[j], start: cyc});
                    busy_until[j] = cyc + 2*hv(j)*(F+1);
                    next_free[j]  = cyc + 2*hv(j)*(F+1) + 2;
                end
            end
        end
    end

    // Monitor: record the line, and on each irq retire the oldest frame.
    initial forever begin
        @(negedge clock);
        for (int j = 0; j < 3; j++) begin
            hist[j][cyc % N] = led[j];
            if (irq[j] === 1'b1) begin
                int   fi;
                int   len;
                int   bad;
                exp_t e;
                fi = -1;
                foreach (q[i]) if (fi < 0 && q[i].inst == j) fi = i;
                vec++;
                if (fi < 0) begin
                    miss++;
                    $display("FAIL spurious_irq inst%0d cycle %0d: irq=1, no frame outstanding", j, cyc);
                end else begin
                    e = q[fi];
                    q.delete(fi);
                    len = 2*hv(j)*(F+1);
                    vec++;
                    if (cyc != e.start + len) begin
                        miss++;
                        $display("FAIL irq_time inst%0d: irq at %0d cycles after start, need %0d",
                                 j, cyc - e.start, len);
                    end
                    bad = -1;
                    for (int off = 0; off < len; off++)
                        if (bad < 0 && hist[j][(e.start + off) % N] !== exp_led(e.d, hv(j), off))
                            bad = off;
                    vec++;
                    if (bad >= 0) begin
                        miss++;
                        $display("FAIL wave inst%0d data %h offset %0d: led=%b need %b", j, e.d, bad,
                                 hist[j][(e.start + bad) % N], exp_led(e.d, hv(j), bad));
                    end
                    vec++;
                    if (led[j] !== 1'b0) begin
                        miss++;
                        $display("FAIL done_led inst%0d: led=%b need 0", j, led[j]);
                    end
                end
            end else if (cyc > busy_until[j]) begin
                vec++;
                if (led[j] !== 1'b0 || irq[j] !== 1'b0) begin
                    miss++;
                    $display("FAIL idle inst%0d cycle %0d: led=%b irq=%b need 0 0", j, cyc, led[j], irq[j]);
                end
            end
        end
    end

    // Outputs must clear as soon as reset falls, without waiting for a clock.
    initial forever begin
        @(negedge reset);
        #1;
        for (int j = 0; j < 3; j++) begin
            vec++;
            if (led[j] !== 1'b0 || irq[j] !== 1'b0) begin
                miss++;
                $display("FAIL reset inst%0d: led=%b irq=%b need 0 0", j, led[j], irq[j]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send(input int j, input logic [15:0] d, input int hold, input int gap);
        data[j]   = d;
        enable[j] = 1'b1;
        tick(hold);
        enable[j] = 1'b0;
        tick(gap);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            enable[j] = 1'b0;
            data[j]   = '0;
        end
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        tick(2);

        // Single known frame.
        send(0, 16'h4FB6, 1, 140);

        // Abort mid data bit 5, then stay idle.
        data[0]   = 16'($urandom);
        enable[0] = 1'b1;
        tick(1);
        enable[0] = 1'b0;
        tick(51);
        #1 reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(100);

        // Data changed in flight is ignored.
        data[0]   = 16'hFFFF;
        enable[0] = 1'b1;
        tick(1);
        enable[0] = 1'b0;
        tick(9);
        data[0] = 16'h0000;
        tick(130);

        // Back-to-back with enable held.
        data[0]   = 16'h0001;
        enable[0] = 1'b1;
        tick(1);
        data[0] = 16'h8000;
        tick(137);
        data[0] = 16'($urandom);
        tick(100);
        enable[0] = 1'b0;
        tick(40);

        // Idle gating, single-cycle pulse, enable dropped mid-frame.
        tick(200);
        send(0, 16'($urandom), 1, 140);
        send(0, 16'($urandom), 30, 110);

        // Random frames with ragged enable widths and gaps.
        for (int n = 0; n < 6; n++)
            send(0, 16'($urandom), $urandom_range(1, 3), $urandom_range(132, 150));

        // Other half-bit lengths.
        send(1, 16'hA5A5, 1, 40);
        send(2, 16'hA5A5, 1, 245);
        for (int n = 0; n < 3; n++) begin
            send(1, 16'($urandom), $urandom_range(1, 2), $urandom_range(34, 45));
            send(2, 16'($urandom), $urandom_range(1, 2), $urandom_range(238, 250));
        end

        tick(10);
        vec++;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL drained: %0d frames without irq, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
